// File: rtl/pipeline_1_decode.sv
// Decode/register-read stage of the 16-bit in-order pipeline: one-entry instruction
// register, 8x16 register file with writeback bypass and a per-register RAW/WAW scoreboard.
module pipeline_1_decode #(
    parameter int control_width = 22
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     if_valid,
    input  logic [15:0]              if_instr,
    output logic                     id_ready,
    input  logic                     wb_en,
    input  logic [2:0]               wb_num,
    input  logic [15:0]              wb_data,
    output logic [control_width-1:0] control_out,
    output logic [15:0]              Rm,
    output logic [15:0]              Rn,
    output logic [15:0]              Rram,
    output logic [15:0]              imm_out,
    output logic [2:0]               read_num_m,
    output logic [2:0]               read_num_n,
    output logic [2:0]               read_num_ram,
    output logic                     stall,
    output logic                     halted
);
    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] ir;
    logic [15:0] regs [8];
    logic [7:0]  pend;

    logic [2:0]  opc;
    logic [1:0]  op;
    logic [1:0]  sh;
    logic [2:0]  f_rn;
    logic [2:0]  f_rd;
    logic [2:0]  f_rm;
    logic [15:0] sx_imm8;
    logic [15:0] sx_imm5;

    logic        dec_valid;
    logic        dec_halt;
    logic [2:0]  dest;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  wb_sel;
    logic        asel;
    logic        bsel;
    logic        loads;
    logic [1:0]  alu_op;
    logic [1:0]  shift;
    logic [15:0] imm;
    logic [2:0]  num_m;
    logic [2:0]  num_n;
    logic [2:0]  num_ram;
    logic        use_m;
    logic        use_n;
    logic        use_ram;

    logic [21:0] ctrl;
    logic [7:0]  clr_mask;
    logic [7:0]  set_mask;
    logic [7:0]  pend_live;
    logic        hazard;
    logic        issue;

    assign opc     = ir[15:13];
    assign op      = ir[12:11];
    assign f_rn    = ir[10:8];
    assign f_rd    = ir[7:5];
    assign sh      = ir[4:3];
    assign f_rm    = ir[2:0];
    assign sx_imm8 = {{8{ir[7]}}, ir[7:0]};
    assign sx_imm5 = {{11{ir[4]}}, ir[4:0]};

    // Decode is gated on a held instruction so an empty or halted stage reads register 0
    // with no sources and no immediate.
    always_comb begin
        dec_valid = 1'b0;
        dec_halt  = 1'b0;
        dest      = 3'd0;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        wb_sel    = 2'b00;
        asel      = 1'b0;
        bsel      = 1'b0;
        loads     = 1'b0;
        alu_op    = 2'b00;
        shift     = 2'b00;
        imm       = 16'd0;
        num_m     = 3'd0;
        num_n     = 3'd0;
        num_ram   = 3'd0;
        use_m     = 1'b0;
        use_n     = 1'b0;
        use_ram   = 1'b0;
        if (state == HOLD) begin
            case (opc)
                3'b110: begin
                    if (op == 2'b10) begin
                        dec_valid = 1'b1;
                        dest      = f_rn;
                        reg_write = 1'b1;
                        asel      = 1'b1;
                        bsel      = 1'b1;
                        imm       = sx_imm8;
                    end else if (op == 2'b00) begin
                        dec_valid = 1'b1;
                        dest      = f_rd;
                        reg_write = 1'b1;
                        bsel      = 1'b1;
                        shift     = sh;
                        num_m     = f_rm;
                        use_m     = 1'b1;
                    end
                end
                3'b101: begin
                    dec_valid = 1'b1;
                    alu_op    = op;
                    shift     = sh;
                    num_m     = f_rm;
                    num_n     = f_rn;
                    use_m     = 1'b1;
                    use_n     = 1'b1;
                    if (op == 2'b01) begin
                        loads = 1'b1;
                    end else begin
                        dest      = f_rd;
                        reg_write = 1'b1;
                    end
                end
                3'b011: begin
                    if (op == 2'b00) begin
                        dec_valid = 1'b1;
                        dest      = f_rd;
                        reg_write = 1'b1;
                        mem_read  = 1'b1;
                        wb_sel    = 2'b01;
                        bsel      = 1'b1;
                        imm       = sx_imm5;
                        num_m     = f_rn;
                        use_m     = 1'b1;
                    end
                end
                3'b100: begin
                    if (op == 2'b00) begin
                        dec_valid = 1'b1;
                        mem_write = 1'b1;
                        bsel      = 1'b1;
                        imm       = sx_imm5;
                        num_m     = f_rn;
                        num_ram   = f_rd;
                        use_m     = 1'b1;
                        use_ram   = 1'b1;
                    end
                end
                3'b111: begin
                    dec_valid = 1'b1;
                    dec_halt  = 1'b1;
                end
                default: begin
                    dec_valid = 1'b0;
                end
            endcase
        end
    end

    assign ctrl = {dec_valid, dec_halt, dest, reg_write, mem_read, mem_write, wb_sel,
                   1'b0, asel, bsel, loads, alu_op, shift, 4'b0000};

    // A register being written back this cycle no longer blocks, so its consumer issues now.
    assign clr_mask  = wb_en ? (8'b1 << wb_num) : 8'b0;
    assign pend_live = pend & ~clr_mask;
    assign hazard    = (use_m & pend_live[num_m]) | (use_n & pend_live[num_n]) |
                       (use_ram & pend_live[num_ram]) | (reg_write & pend_live[dest]);
    assign issue     = (state == HOLD) & ~hazard;
    assign set_mask  = (issue & reg_write) ? (8'b1 << dest) : 8'b0;

    assign id_ready     = (state != HALTED) & ((state != HOLD) | issue);
    assign stall        = (state == HOLD) & hazard;
    assign halted       = (state == HALTED);
    assign control_out  = issue ? control_width'(ctrl) : '0;
    assign imm_out      = imm;
    assign read_num_m   = num_m;
    assign read_num_n   = num_n;
    assign read_num_ram = num_ram;
    assign Rm           = (wb_en && wb_num == num_m)   ? wb_data : regs[num_m];
    assign Rn           = (wb_en && wb_num == num_n)   ? wb_data : regs[num_n];
    assign Rram         = (wb_en && wb_num == num_ram) ? wb_data : regs[num_ram];

    // Register file written directly from writeback.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= 16'd0;
            end
        end else if (wb_en) begin
            regs[wb_num] <= wb_data;
        end
    end

    // Instruction register, scoreboard and stage state; a newly issued destination
    // overrides a same-edge writeback clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
            ir    <= 16'd0;
            pend  <= 8'd0;
        end else begin
            pend <= (pend & ~clr_mask) | set_mask;
            case (state)
                EMPTY: begin
                    if (if_valid) begin
                        ir    <= if_instr;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (issue && dec_halt) begin
                        ir    <= 16'd0;
                        state <= HALTED;
                    end else if (issue) begin
                        if (if_valid) begin
                            ir <= if_instr;
                        end else begin
                            state <= EMPTY;
                        end
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end
endmodule

// File: doc/pipeline_1_decode.md
# pipeline_1_decode

Decode/register-read stage of the 16-bit in-order pipeline. Accepts instructions from fetch over a valid/ready handshake, holds them in an instruction register and decodes them into the 22-bit control word. It reads operands from its internal 8x16 register file and presents control word, operands and register numbers to the execute stage, which registers them on the next edge. A per-register scoreboard stalls issue on RAW/WAW hazards until writeback returns the result.

## Interface
- control_width, 22, control word width; layout below is fixed for 22.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low.
- if_valid  in  1  fetch presents an instruction.
- if_instr  in  16  instruction word.
- id_ready  out  1  stage accepts if_instr this edge.
- wb_en  in  1  writeback writes the register file.
- wb_num  in  3  writeback register number.
- wb_data  in  16  writeback data.
- control_out  out  22  control word to execute.
- Rm, Rn, Rram  out  16  operand values (bypassed reads of read_num_m/n/ram).
- imm_out  out  16  sign-extended immediate.
- read_num_m, read_num_n, read_num_ram  out  3  register numbers.
- stall  out  1  valid instruction held this cycle by a hazard.
- halted  out  1  HALT issued; stage frozen.

## Operation
- Fields: opc[15:13], op[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0], imm8[7:0], imm5[4:0].
- Control word: [21] valid, [20] halt, [19:17] dest, [16] reg_write, [15] mem_read, [14] mem_write, [13:12] wb_sel (00 ALU, 01 memory), [11] 0, [10] asel, [9] bsel, [8] loads, [7:6] ALUop, [5:4] shift, [3:0] 0. Execute computes result = (bsel ? imm : Rn) op (asel ? 0 : shift(Rm)).
- MOV Rn,#imm8 (110,10): imm=sx(imm8), asel=1, bsel=1, ALUop 00, dest=Rn, reg_write.
- MOV Rd,Rm{sh} (110,00): imm=0, bsel=1, asel=0, shift=sh, dest=Rd.
- ALU (101,op): read_num_n=Rn, read_num_m=Rm, ALUop=op, shift=sh; ADD/AND/MVN write Rd; CMP (op 01) sets loads=1, no write.
- LDR (011,00): read_num_m=Rn, shift 00, imm=sx(imm5), bsel=1, asel=0, mem_read, wb_sel 01, dest=Rd.
- STR (100,00): as LDR address, mem_write, read_num_ram=Rd, no write.
- HALT (111): valid=1, halt=1, all else 0.
- All other encodings: consumed, issued as bubble (control_out=0).
- Unused read numbers = 0 and are not hazard sources.
- Scoreboard pend[7:0]: hazard = sources used or dest pending, excluding any register cleared by wb_en this cycle. Issue sets pend[dest]; wb_en clears pend[wb_num]; same register set and cleared in one edge -> set wins.
- Register file: write on edge when wb_en. Read bypass: read number == wb_num with wb_en -> wb_data.
- States: EMPTY (ir_valid=0), HOLD (ir_valid=1), HALTED. issue = ir_valid & ~hazard & ~halted. id_ready = ~halted & (~ir_valid | issue). Not issuing -> control_out=0.
- HALT issues, IR clears, enters HALTED; leaves only via rst.

## Timing
- Reset (async, rst=0): regfile, pend, IR, ir_valid, halted all 0. control_out=0, operands=0, read nums=0, stall=0, id_ready=1 after release.
- Instruction accepted at edge k: decoded combinationally in cycle k..k+1, captured by execute at edge k+1 if no hazard. Throughput 1/cycle when hazard-free.
- stall = ir_valid & hazard & ~halted; IR held, id_ready=0, bubble issued.
- wb_en for a pending source in cycle c: hazard drops in c, instruction issues with bypassed wb_data at edge ending c.
- rst asserted mid-stall: IR and scoreboard cleared immediately; held instruction lost.

## Test plan
- Reset, then if_instr=0xD105 (MOV R1,#5) -> next cycle control_out valid, dest=1, reg_write, asel=bsel=1, imm_out=0x0005; pend[1]=1.
- 0xD105 then 0xA141 (ADD R2,R1,R1) -> stall=1, id_ready=0 until wb_en/wb_num=1/wb_data=5; that cycle Rm=Rn=5, issues, dest=2.
- 0x6162 (LDR R3,[R1,#2]) with R1 written -> read_num_m=1, imm_out=2, bsel=1, mem_read, wb_sel=01, dest=3.
- 0xA902 (CMP R1,R2) -> loads=1, ALUop=01, reg_write=0, pend unchanged.
- 0xE000 (HALT) -> control_out bits 21,20 set, halted=1, id_ready stays 0 with if_valid=1.
- Stalled on R1, pulse rst low -> control_out=0, pend=0, id_ready=1 after release.
